word_field_accum: RTL and testbench

WORD_FIELD_ACCUM -- requirements
Module: word_field_accum

---
 rtl/word_field_accum.sv | 127 ++++++++++++
 tb/tb_word_field_accum.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_field_accum.sv
// word_field_accum
//   Collects ACC_LEN accepted 12-bit words into one result. Each word packs a
//   signed 8-bit field A [11:4] and an unsigned 4-bit field B [3:0]. Field A
//   is summed into a 12-bit signed accumulator that saturates. Any clamp sets
//   a sticky flag. Field B is ORed into a mask. The result is held until the
//   downstream handshake takes it.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort; drops partial or held result
//   in_word    in   {A[11:4] signed, B[3:0] unsigned}
//   in_valid   in   in_word valid
//   in_ready   out  block accepts in_word (collecting state)
//   out_sum    out  saturated signed sum of field A (always the accumulator)
//   out_mask   out  OR of field B over the batch
//   out_sat    out  saturation occurred during the batch
//   out_valid  out  result valid (holding state)
//   out_ready  in   downstream accepts result
module word_field_accum #(
    parameter int unsigned ACC_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [11:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] out_sum,
    output logic [3:0]  out_mask,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [11:0] r_acc;
    logic [3:0]  r_mask;
    logic        r_sat;
    logic [7:0]  r_cnt;

    logic        w_accept;
    logic        w_last;
    logic        w_release;
    logic [7:0]  w_a;
    logic [12:0] w_sum13;
    logic [11:0] w_sum_sat;
    logic        w_clamp;

    assign w_a       = in_word[11:4];
    assign w_accept  = in_valid & in_ready & ~clear;
    assign w_last    = (r_cnt == 8'(ACC_LEN - 1));
    assign w_release = (r_state == HOLD) & out_ready;

    // 13-bit sum of sign-extended operands; the top two bits disagree only
    // when the true result falls outside the 12-bit signed range.
    assign w_sum13 = {r_acc[11], r_acc} + {{5{w_a[7]}}, w_a};

    always_comb begin
        w_sum_sat = w_sum13[11:0];
        w_clamp   = 1'b0;
        if (w_sum13[12:11] == 2'b01) begin
            w_sum_sat = 12'h7FF;
            w_clamp   = 1'b1;
        end else if (w_sum13[12:11] == 2'b10) begin
            w_sum_sat = 12'h800;
            w_clamp   = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear wins over every other event
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_accept && w_last) w_next_state = HOLD;
                HOLD:    if (out_ready)          w_next_state = ACCUM;
                default: w_next_state = ACCUM;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = (r_state == ACCUM);
        out_valid = (r_state == HOLD);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_mask <= '0;
            r_sat  <= 1'b0;
            r_cnt  <= '0;
        end else if (clear || w_release) begin
            r_acc  <= '0;
            r_mask <= '0;
            r_sat  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_acc  <= w_sum_sat;
            r_mask <= r_mask | in_word[3:0];
            r_sat  <= r_sat | w_clamp;
            r_cnt  <= w_last ? 8'd0 : r_cnt + 8'd1;
        end
    end

    assign out_sum  = r_acc;
    assign out_mask = r_mask;
    assign out_sat  = r_sat;

endmodule

// File: tb/tb_word_field_accum.sv
module tb_word_field_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [11:0] in_word;
    logic        in_valid;
    logic        out_ready;

    // Index 0: ACC_LEN=4, 1: ACC_LEN=20, 2: ACC_LEN=1 (all share inputs)
    logic        in_ready  [3];
    logic [11:0] out_sum   [3];
    logic [3:0]  out_mask  [3];
    logic        out_sat   [3];
    logic        out_valid [3];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: batch progress per instance, plain integer arithmetic
    int acc_len [3] = '{4, 20, 1};
    int m_acc   [3];
    int m_mask  [3];
    bit m_sat   [3];
    int m_cnt   [3];
    bit m_hold  [3];

    always #5 clk = ~clk;

    word_field_accum #(.ACC_LEN(4)) u_len4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_word(in_word),
        .in_valid(in_valid), .in_ready(in_ready[0]), .out_sum(out_sum[0]),
        .out_mask(out_mask[0]), .out_sat(out_sat[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready)
    );

    word_field_accum #(.ACC_LEN(20)) u_len20 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_word(in_word),
        .in_valid(in_valid), .in_ready(in_ready[1]), .out_sum(out_sum[1]),
        .out_mask(out_mask[1]), .out_sat(out_sat[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready)
    );

    word_field_accum #(.ACC_LEN(1)) u_len1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_word(in_word),
        .in_valid(in_valid), .in_ready(in_ready[2]), .out_sum(out_sum[2]),
        .out_mask(out_mask[2]), .out_sat(out_sat[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_acc[i]  = 0;
        m_mask[i] = 0;
        m_sat[i]  = 1'b0;
        m_cnt[i]  = 0;
        m_hold[i] = 1'b0;
    endtask

    // What one rising edge does to a batch, given the current inputs
    task automatic model_edge();
        int a;
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                model_reset(i);
            end else if (m_hold[i]) begin
                if (out_ready) model_reset(i);
            end else if (in_valid) begin
                a = int'($signed(in_word[11:4]));
                m_acc[i] = m_acc[i] + a;
                if (m_acc[i] > 2047) begin
                    m_acc[i] = 2047;
                    m_sat[i] = 1'b1;
                end else if (m_acc[i] < -2048) begin
                    m_acc[i] = -2048;
                    m_sat[i] = 1'b1;
                end
                m_mask[i] = m_mask[i] | int'(in_word[3:0]);
                m_cnt[i]++;
                if (m_cnt[i] == acc_len[i]) begin
                    m_hold[i] = 1'b1;
                    m_cnt[i]  = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [11:0] s;
        logic [3:0]  m;
        for (int i = 0; i < 3; i++) begin
            s = m_acc[i][11:0];
            m = m_mask[i][3:0];
            chk($sformatf("model_in_ready[%0d]", i),  32'(in_ready[i]),  32'(!m_hold[i]));
            chk($sformatf("model_out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_hold[i]));
            chk($sformatf("model_out_sum[%0d]", i),   32'(out_sum[i]),   32'(s));
            chk($sformatf("model_out_mask[%0d]", i),  32'(out_mask[i]),  32'(m));
            chk($sformatf("model_out_sat[%0d]", i),   32'(out_sat[i]),   32'(m_sat[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic c, input logic v, input logic [11:0] w, input logic r);
        clear     = c;
        in_valid  = v;
        in_word   = w;
        out_ready = r;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 1'b1);
        for (int i = 0; i < 3; i++) model_reset(i);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_in_ready", 32'(in_ready[0]), 32'd1);
        chk("reset_out_sum",  32'(out_sum[0]),  32'h000);
        rst_n = 1'b1;

        // Four words FBA back-to-back, first edge after reset accepts
        drive(1'b0, 1'b1, 12'hFBA, 1'b1);
        repeat (4) tick();
        chk("b29_valid", 32'(out_valid[0]), 32'd1);
        chk("b29_sum",   32'(out_sum[0]),   32'hFEC);
        chk("b29_mask",  32'(out_mask[0]),  32'hA);
        chk("b29_sat",   32'(out_sat[0]),   32'd0);
        drive(1'b0, 1'b0, 12'h000, 1'b1);
        tick();
        chk("b29_valid_one_cycle", 32'(out_valid[0]), 32'd0);

        // Positive and negative saturation on ACC_LEN=20
        drive(1'b1, 1'b0, 12'h000, 1'b1);
        tick();
        drive(1'b0, 1'b1, 12'h7F1, 1'b1);
        repeat (20) tick();
        chk("b30p_valid", 32'(out_valid[1]), 32'd1);
        chk("b30p_sum",   32'(out_sum[1]),   32'h7FF);
        chk("b30p_sat",   32'(out_sat[1]),   32'd1);
        chk("b30p_mask",  32'(out_mask[1]),  32'h1);
        drive(1'b0, 1'b0, 12'h000, 1'b1);
        tick();
        drive(1'b0, 1'b1, 12'h802, 1'b1);
        repeat (20) tick();
        chk("b30n_sum",  32'(out_sum[1]),  32'h800);
        chk("b30n_sat",  32'(out_sat[1]),  32'd1);
        chk("b30n_mask", 32'(out_mask[1]), 32'h2);

        // Back-pressure while holding
        drive(1'b1, 1'b0, 12'h000, 1'b0);
        tick();
        drive(1'b0, 1'b1, 12'h011, 1'b0);
        repeat (4) tick();
        chk("b31_valid", 32'(out_valid[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("b31_in_ready_held", 32'(in_ready[0]), 32'd0);
            chk("b31_sum_held",      32'(out_sum[0]),  32'h004);
        end
        drive(1'b0, 1'b0, 12'h011, 1'b1);
        tick();
        chk("b31_release_ready", 32'(in_ready[0]), 32'd1);
        chk("b31_release_sum",   32'(out_sum[0]),  32'h000);
        drive(1'b0, 1'b1, 12'h011, 1'b1);
        repeat (4) tick();
        chk("b31_next_sum", 32'(out_sum[0]), 32'h004);

        // Abort mid-batch with clear
        drive(1'b1, 1'b0, 12'h000, 1'b1);
        tick();
        drive(1'b0, 1'b1, 12'h050, 1'b1);
        repeat (2) tick();
        drive(1'b1, 1'b1, 12'h050, 1'b1);
        tick();
        chk("b32_clear_sum", 32'(out_sum[0]), 32'h000);
        drive(1'b0, 1'b1, 12'h013, 1'b1);
        repeat (4) tick();
        chk("b32_sum",  32'(out_sum[0]),  32'h004);
        chk("b32_mask", 32'(out_mask[0]), 32'h3);

        // Asynchronous reset between edges, mid-batch
        drive(1'b1, 1'b0, 12'h000, 1'b1);
        tick();
        drive(1'b0, 1'b1, 12'h101, 1'b1);
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) model_reset(i);
        check_all();
        chk("b33_async_sum",   32'(out_sum[0]),  32'h000);
        chk("b33_async_ready", 32'(in_ready[0]), 32'd1);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        chk("b33_sum",   32'(out_sum[0]),   32'h040);
        chk("b33_valid", 32'(out_valid[0]), 32'd1);

        // ACC_LEN=1 continuous input
        drive(1'b1, 1'b0, 12'h000, 1'b1);
        tick();
        drive(1'b0, 1'b1, 12'h804, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("b34_valid", 32'(out_valid[2]), 32'((k % 2) == 0));
            if ((k % 2) == 0) begin
                chk("b34_sum", 32'(out_sum[2]), 32'hF80);
                chk("b34_sat", 32'(out_sat[2]), 32'd0);
            end
        end

        // Randomized traffic against the model, biased toward saturation
        for (int k = 0; k < 400; k++) begin
            logic [11:0] w;
            w = 12'($urandom);
            case ($urandom_range(0, 3))
                0: w[11:4] = 8'h7F;
                1: w[11:4] = 8'h80;
                default: ;
            endcase
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, w,
                  $urandom_range(0, 2) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
